// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : funct3 encodings, FSM state type and access-check helpers for
//            the data-memory unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: return 1'b1;
      F3_H, F3_HU: return ~lo[0];
      default:     return (lo == 2'b00);
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] f3, input logic is_store);
    if (is_store)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_unit_if.sv
// ============================================================================
// Module   : data_mem_unit_if
// Purpose  : Load/store request bus between core (master) and data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface data_mem_unit_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output mem_rd, mem_wr, funct3, addr, wr_data,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  mem_rd, mem_wr, funct3, addr, wr_data,
    output rd_data, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// ============================================================================
// Module   : dmem_lane_align
// Purpose  : Byte-lane steering for stores and sign/zero extension for loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wr_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfword and word sizes ignore the low address bits, which also gives the
  // forced-alignment behaviour when misalignment is not trapped.
  always_comb begin
    byte_en = 4'b0000;
    st_word = 32'h0;
    ld_data = 32'h0;
    w_byte  = 8'h0;
    w_half  = 16'h0;
    case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_lo;
        st_word = {4{wr_data[7:0]}};
        case (addr_lo)
          2'd0:    w_byte = rd_word[7:0];
          2'd1:    w_byte = rd_word[15:8];
          2'd2:    w_byte = rd_word[23:16];
          default: w_byte = rd_word[31:24];
        endcase
        ld_data = funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_word = {2{wr_data[15:0]}};
        w_half  = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      end
      default: begin
        byte_en = 4'b1111;
        st_word = wr_data;
        ld_data = rd_word;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_unit.sv
// ============================================================================
// Module   : data_mem_unit
// Purpose  : Multi-cycle load/store responder with byte enables and load
//            extension. Define DMEM_ERR_EN to trap misaligned/illegal access.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  data_mem_unit_if.slave   bus
);

  localparam int         c_idx_w    = $clog2(DEPTH_WORDS);
  localparam logic [2:0] c_cnt_init = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic [c_idx_w+1:0] r_addr;
  logic [2:0]         r_f3;
  logic [31:0]        r_wdata;
  logic               r_op_wr;
  logic [31:0]        r_rd_data;
  logic               r_done;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_req;
  logic               w_idle;
  logic               w_enter_resp;
  logic [c_idx_w+1:0] w_sel_addr;
  logic [2:0]         w_sel_f3;
  logic [31:0]        w_sel_wdata;
  logic               w_sel_wr;
  logic               w_legal;
  logic               w_fault;
  logic [2:0]         w_eff_f3;
  logic [c_idx_w-1:0] w_idx;
  logic [31:0]        w_raw;
  logic [3:0]         w_be;
  logic [31:0]        w_st_word;
  logic [31:0]        w_ld_data;
  logic               w_unused_addr;

  assign w_req        = bus.mem_rd | bus.mem_wr;
  assign w_idle       = (r_state == IDLE);
  assign w_enter_resp = (w_idle && w_req && (LATENCY == 0)) ||
                        ((r_state == WAIT) && (r_cnt == 3'd0));

  // With zero latency the access happens on the acceptance edge, before the
  // latches hold anything, so the live bus is used while still in IDLE.
  assign w_sel_addr  = w_idle ? bus.addr[c_idx_w+1:0] : r_addr;
  assign w_sel_f3    = w_idle ? bus.funct3 : r_f3;
  assign w_sel_wdata = w_idle ? bus.wr_data : r_wdata;
  assign w_sel_wr    = w_idle ? bus.mem_wr : r_op_wr;

  assign w_legal  = is_legal(w_sel_f3, w_sel_wr);
  assign w_eff_f3 = w_legal ? w_sel_f3 : F3_W;
`ifdef DMEM_ERR_EN
  assign w_fault  = ~w_legal | ~is_aligned(w_sel_f3, w_sel_addr[1:0]);
`else
  assign w_fault  = 1'b0;
`endif

  assign w_idx = w_sel_addr[c_idx_w+1:2];
  assign w_raw = r_mem[w_idx];

  // Upper address bits alias onto the array.
  assign w_unused_addr = &{1'b0, bus.addr[31:c_idx_w+2]};

  dmem_lane_align u_align (
    .funct3  (w_eff_f3),
    .addr_lo (w_sel_addr[1:0]),
    .wr_data (w_sel_wdata),
    .rd_word (w_raw),
    .byte_en (w_be),
    .st_word (w_st_word),
    .ld_data (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst_n && w_enter_resp && w_sel_wr && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_st_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_rd_data <= 32'h0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus.addr[c_idx_w+1:0];
            r_f3    <= bus.funct3;
            r_wdata <= bus.wr_data;
            r_op_wr <= bus.mem_wr;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= c_cnt_init;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0)
            r_state <= RESP;
          else
            r_cnt <= r_cnt - 3'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_enter_resp) begin
        r_done    <= 1'b1;
        r_err     <= w_fault;
        r_rd_data <= (w_sel_wr || w_fault) ? 32'h0 : w_ld_data;
      end
    end
  end

  assign bus.busy    = (w_idle && w_req) || (r_state == WAIT);
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_unit.sv
// ============================================================================
// Module   : tb_data_mem_unit
// Purpose  : Directed bench driving a LATENCY=2 and a LATENCY=0 instance in
//            lockstep with hand-computed expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_unit;
  import dmem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        t_rd;
  logic        t_wr;
  logic [2:0]  t_f3;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  int          checks;
  int          errors;

`ifdef DMEM_ERR_EN
  localparam bit c_en = 1'b1;
`else
  localparam bit c_en = 1'b0;
`endif

  data_mem_unit_if bus2 ();
  data_mem_unit_if bus0 ();

  assign bus2.mem_rd  = t_rd;
  assign bus2.mem_wr  = t_wr;
  assign bus2.funct3  = t_f3;
  assign bus2.addr    = t_addr;
  assign bus2.wr_data = t_wdata;
  assign bus0.mem_rd  = t_rd;
  assign bus0.mem_wr  = t_wr;
  assign bus0.funct3  = t_f3;
  assign bus0.addr    = t_addr;
  assign bus0.wr_data = t_wdata;

  data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One transaction: request for a single cycle, then check both responders.
  task automatic acc(input string tag, input logic rd, input logic wr,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp2, input logic [31:0] exp0, input logic exp_err);
    @(posedge clk); #1;
    t_rd = rd; t_wr = wr; t_f3 = f3; t_addr = a; t_wdata = d;
    @(negedge clk);
    chk({tag, ".c0.busy2"}, 32'(bus2.busy), 32'd1);
    chk({tag, ".c0.busy0"}, 32'(bus0.busy), 32'd1);
    @(posedge clk); #1;
    t_rd = 1'b0; t_wr = 1'b0;
    @(negedge clk);
    chk({tag, ".c1.done0"}, 32'(bus0.done), 32'd1);
    chk({tag, ".c1.busy0"}, 32'(bus0.busy), 32'd0);
    chk({tag, ".c1.rd0"},   bus0.rd_data,   exp0);
    chk({tag, ".c1.err0"},  32'(bus0.err),  32'(exp_err));
    chk({tag, ".c1.busy2"}, 32'(bus2.busy), 32'd1);
    chk({tag, ".c1.done2"}, 32'(bus2.done), 32'd0);
    @(negedge clk);
    chk({tag, ".c2.busy2"}, 32'(bus2.busy), 32'd1);
    chk({tag, ".c2.done2"}, 32'(bus2.done), 32'd0);
    chk({tag, ".c2.done0"}, 32'(bus0.done), 32'd0);
    @(negedge clk);
    chk({tag, ".c3.done2"}, 32'(bus2.done), 32'd1);
    chk({tag, ".c3.busy2"}, 32'(bus2.busy), 32'd0);
    chk({tag, ".c3.rd2"},   bus2.rd_data,   exp2);
    chk({tag, ".c3.err2"},  32'(bus2.err),  32'(exp_err));
    @(negedge clk);
    chk({tag, ".c4.done2"}, 32'(bus2.done), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; t_rd = 1'b0; t_wr = 1'b0;
    t_f3 = F3_W; t_addr = 32'h0; t_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rd2",   bus2.rd_data,   32'h0);
    chk("rst.done2", 32'(bus2.done), 32'd0);
    chk("rst.err2",  32'(bus2.err),  32'd0);
    chk("rst.busy2", 32'(bus2.busy), 32'd0);
    chk("rst.busy0", 32'(bus0.busy), 32'd0);
    chk("rst.done0", 32'(bus0.done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset during WAIT drops the store on the LATENCY=2 instance only.
    acc("sw10a", 1'b0, 1'b1, F3_W, 32'h10, 32'h1111_1111, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    t_wr = 1'b1; t_f3 = F3_W; t_addr = 32'h10; t_wdata = 32'h2222_2222;
    @(posedge clk); #1;
    t_wr = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw.busy2", 32'(bus2.busy), 32'd0);
    chk("rstw.done2", 32'(bus2.done), 32'd0);
    chk("rstw.done0", 32'(bus0.done), 32'd0);
    @(negedge clk);
    chk("rstw.done2b", 32'(bus2.done), 32'd0);
    acc("lw10", 1'b1, 1'b0, F3_W, 32'h10, 32'h0, 32'h1111_1111, 32'h2222_2222, 1'b0);

    acc("sw8", 1'b0, 1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
    acc("lw8", 1'b1, 1'b0, F3_W, 32'h8, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);

    acc("sw20",  1'b0, 1'b1, F3_W,  32'h20, 32'h0,  32'h0, 32'h0, 1'b0);
    acc("sb21",  1'b0, 1'b1, F3_B,  32'h21, 32'h81, 32'h0, 32'h0, 1'b0);
    acc("lb21",  1'b1, 1'b0, F3_B,  32'h21, 32'h0,  32'hFFFF_FF81, 32'hFFFF_FF81, 1'b0);
    acc("lbu21", 1'b1, 1'b0, F3_BU, 32'h21, 32'h0,  32'h0000_0081, 32'h0000_0081, 1'b0);
    acc("lw20",  1'b1, 1'b0, F3_W,  32'h20, 32'h0,  32'h0000_8100, 32'h0000_8100, 1'b0);

    acc("sw44",  1'b0, 1'b1, F3_W,  32'h44, 32'h0,      32'h0, 32'h0, 1'b0);
    acc("sh46",  1'b0, 1'b1, F3_H,  32'h46, 32'hBEEF,   32'h0, 32'h0, 1'b0);
    acc("lh46",  1'b1, 1'b0, F3_H,  32'h46, 32'h0,      32'hFFFF_BEEF, 32'hFFFF_BEEF, 1'b0);
    acc("lhu46", 1'b1, 1'b0, F3_HU, 32'h46, 32'h0,      32'h0000_BEEF, 32'h0000_BEEF, 1'b0);
    acc("lw44",  1'b1, 1'b0, F3_W,  32'h44, 32'h0,      32'hBEEF_0000, 32'hBEEF_0000, 1'b0);

    // Misalignment and illegal funct3: trapped with the feature, coerced without.
    acc("sw4", 1'b0, 1'b1, F3_W, 32'h4, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
    acc("lw6", 1'b1, 1'b0, F3_W, 32'h6, 32'h0,
        c_en ? 32'h0 : 32'h1234_5678, c_en ? 32'h0 : 32'h1234_5678, c_en);
    acc("sw5", 1'b0, 1'b1, F3_W, 32'h5, 32'hAAAA_AAAA, 32'h0, 32'h0, c_en);
    acc("lw4", 1'b1, 1'b0, F3_W, 32'h4, 32'h0,
        c_en ? 32'h1234_5678 : 32'hAAAA_AAAA, c_en ? 32'h1234_5678 : 32'hAAAA_AAAA, 1'b0);
    acc("ld011", 1'b1, 1'b0, 3'b011, 32'h4, 32'h0,
        c_en ? 32'h0 : 32'hAAAA_AAAA, c_en ? 32'h0 : 32'hAAAA_AAAA, c_en);

    // Store wins when both strobes are high; upper address bits alias.
    acc("rdwr0", 1'b1, 1'b1, F3_W, 32'h0, 32'h3, 32'h0, 32'h0, 1'b0);
    acc("lw0",    1'b1, 1'b0, F3_W, 32'h0,    32'h0, 32'h3, 32'h3, 1'b0);
    acc("lw1000", 1'b1, 1'b0, F3_W, 32'h1000, 32'h0, 32'h3, 32'h3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
